// File: rtl/mmu_pkg.sv
// Shared encodings for the MMU port arbiter: FSM states, requester owner codes
// and the default watchdog length.
package mmu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESPOND   = 3'd4
  } state_t;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant between fetch and data, either round-robin against the
// last-served owner or fixed data-first.
module rr_arbiter2
  import mmu_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic fetch_req,
  input  logic data_req,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = fetch_req | data_req;
    grant_owner = OWNER_FETCH;
    if (fetch_req && data_req) begin
      // On a tie the round-robin mode serves whoever did not go last.
      grant_owner = (PRIORITY_MODE == 1) ? OWNER_DATA : ~last_owner;
    end else if (data_req) begin
      grant_owner = OWNER_DATA;
    end
  end

endmodule

// File: rtl/mmu_port_arbiter.sv
// Shares MMU port A between instruction fetch and load/store: latches one
// transaction, runs the request/busy handshake and acks with a watchdog.
module mmu_port_arbiter
  import mmu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BUS_WIDTH     = 8,
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT       = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetchRequest,
  input  logic [ADDRESS_WIDTH-1:0] fetchAddr,
  output logic                     fetchAck,
  input  logic                     dataRequest,
  input  logic [ADDRESS_WIDTH-1:0] dataAddr,
  input  logic                     dataWrite,
  input  logic [BUS_WIDTH-1:0]     dataWdata,
  output logic                     dataAck,
  output logic [BUS_WIDTH-1:0]     rdata,
  output logic                     error,
  output logic [ADDRESS_WIDTH-1:0] memAddr,
  output logic                     memRequest,
  output logic                     memWriteEnable,
  output logic [BUS_WIDTH-1:0]     memWdata,
  input  logic [BUS_WIDTH-1:0]     memRdata,
  input  logic                     memBusy
);

  localparam int TIMER_W = $clog2(TIMEOUT) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX   = '1;

  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;
  logic                     last_q, last_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]     wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0]     rdata_q, rdata_d;
  logic                     error_q, error_d;
  logic [TIMER_W-1:0]       timer_q, timer_d;

  logic                     grant_valid;
  logic                     grant_owner;
  logic [TIMER_W-1:0]       timer_inc;
  logic                     timed_out;

  rr_arbiter2 #(
    .PRIORITY_MODE(PRIORITY_MODE)
  ) u_rr_arbiter2 (
    .fetch_req  (fetchRequest),
    .data_req   (dataRequest),
    .last_owner (last_q),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  // The timer counts every cycle spent waiting on the MMU and sticks at max.
  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_W'(1);
  assign timed_out = (timer_inc >= TIMER_LIMIT);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          if (grant_owner == OWNER_DATA) begin
            addr_d  = dataAddr;
            write_d = dataWrite;
            wdata_d = dataWdata;
          end else begin
            addr_d  = fetchAddr;
            write_d = 1'b0;
            wdata_d = '0;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        timer_d = timer_inc;
        if (timed_out) begin
          rdata_d = '0;
          error_d = 1'b1;
          state_d = ST_RESPOND;
        end else if (memBusy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!memBusy) begin
          rdata_d = memRdata;
          error_d = 1'b0;
          state_d = ST_RESPOND;
        end else begin
          timer_d = timer_inc;
          if (timed_out) begin
            rdata_d = '0;
            error_d = 1'b1;
            state_d = ST_RESPOND;
          end
        end
      end
      ST_RESPOND: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_FETCH;
      last_q  <= OWNER_FETCH;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      timer_q <= timer_d;
    end
  end

  assign memRequest     = (state_q == ST_ISSUE);
  assign memWriteEnable = write_q && (state_q != ST_IDLE);
  assign memAddr        = addr_q;
  assign memWdata       = wdata_q;
  assign fetchAck       = (state_q == ST_RESPOND) && (owner_q == OWNER_FETCH);
  assign dataAck        = (state_q == ST_RESPOND) && (owner_q == OWNER_DATA);
  assign rdata          = rdata_q;
  assign error          = error_q;

endmodule

// File: doc/mmu_port_arbiter.md
Name: mmu_port_arbiter

Overview:
- Shares the single writable MMU port (port A: address, request, write enable, data in, data out, busy) between two requesters: instruction fetch (read-only) and load/store (read/write).
- Latches one requester's transaction and drives the MMU request/busy handshake.
- Returns read data with a one-cycle acknowledge pulse.
- Sits between the core front-end/LSU and the MMU; includes a watchdog so a stuck busy cannot hang the core.

Parameters:
- ADDRESS_WIDTH, 32, width of all address buses.
- BUS_WIDTH, 8, data width on the MMU and requester sides.
- PRIORITY_MODE, 0, 0 = round-robin between fetch and data; 1 = data always wins ties.
- TIMEOUT, 64, max cycles spent in WAIT_BUSY plus WAIT_DONE before forced error completion (must be ≥ 4).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- fetchRequest  input  1  fetch wants a read; held until fetchAck.
- fetchAddr  input  ADDRESS_WIDTH  fetch address; stable while fetchRequest is high.
- fetchAck  output  1  one-cycle pulse: fetch transaction complete.
- dataRequest  input  1  LSU wants an access; held until dataAck.
- dataAddr  input  ADDRESS_WIDTH  LSU address.
- dataWrite  input  1  1 = write, 0 = read.
- dataWdata  input  BUS_WIDTH  LSU write data.
- dataAck  output  1  one-cycle pulse: LSU transaction complete.
- rdata  output  BUS_WIDTH  read data; valid during either ack pulse.
- error  output  1  valid with ack; 1 = transaction timed out.
- memAddr  output  ADDRESS_WIDTH  to MMU addrA.
- memRequest  output  1  to MMU requestA.
- memWriteEnable  output  1  to MMU writeEnable.
- memWdata  output  BUS_WIDTH  to MMU dataIn.
- memRdata  input  BUS_WIDTH  from MMU outA.
- memBusy  input  1  from MMU busyA.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Latched address, data, owner and timer cleared.
  - Round-robin pointer points to fetch, so the first tie goes to data.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch owner, address, write flag (forced 0 for fetch) and write data; go to ISSUE.
  - Both requesting, PRIORITY_MODE=0: grant the requester not served last.
  - Both requesting, PRIORITY_MODE=1: grant data.
- ISSUE:
  - Drive memRequest=1 for exactly this one cycle, with memAddr, memWriteEnable and memWdata from the latches.
  - Go to WAIT_BUSY; clear the timer.
- memAddr, memWriteEnable and memWdata hold the latched values from ISSUE through the RESPOND cycle. memWriteEnable drops to 0 in IDLE.
- WAIT_BUSY:
  - memBusy=1: go to WAIT_DONE.
  - memBusy=0: stay; the timer increments.
- WAIT_DONE:
  - memBusy=0: capture memRdata into rdata, error=0, go to RESPOND.
  - memBusy=1: stay; the timer increments.
- Timeout: if the timer reaches TIMEOUT-1 in either wait state, go to RESPOND with rdata=0 and error=1.
- RESPOND:
  - Pulse the owner's ack for one cycle; update the round-robin pointer to the owner.
  - Go to IDLE.
  - Requesters drop or replace their request in the cycle after ack.
- Minimum latency, request to ack: 4 cycles plus MMU busy duration. With busy high for N cycles: request sampled in T0, ack in T(3+N).
- Writes also complete through RESPOND; rdata carries memRdata as captured and must be ignored by the LSU.
- A request arriving while not IDLE is held off; there is no queueing beyond the requester's own hold.
- A requester dropping its request mid-transaction is illegal; the transaction still completes and acks.
- reset mid-transaction: immediate return to IDLE.
  - memRequest and memWriteEnable are 0 the next cycle.
  - No ack is issued for the aborted transaction.
- Timer width is clog2(TIMEOUT)+1; it saturates and never wraps.

Decomposition:
- Shared package (mmu_pkg): state encoding constants (3-bit), owner encoding (OWNER_FETCH=0, OWNER_DATA=1), default TIMEOUT.
- One natural sub-module: rr_arbiter2, a 2-way grant with PRIORITY_MODE and a last-served pointer.
- FSM, latches and timer stay in the top module.

Test Plan:
- Single fetch, addr 0x10; MMU model busy 2 cycles, returns 0xA5 → memRequest high 1 cycle at T1; fetchAck at T5 with rdata=0xA5, error=0; dataAck stays 0.
- Data write, addr 0x120, wdata 0x3C → memWriteEnable=1 with memAddr=0x120 and memWdata=0x3C from ISSUE to RESPOND; dataAck pulses once; fetchAck stays 0.
- Both request continuously, PRIORITY_MODE=0 → grants alternate data, fetch, data, fetch over 4 transactions. Same with PRIORITY_MODE=1 → only data is granted while dataRequest is held.
- MMU model never raises memBusy, TIMEOUT=8 → ack 8 cycles after ISSUE with error=1, rdata=0; the next request proceeds normally.
- reset asserted in WAIT_DONE → next cycle memRequest=0, memWriteEnable=0, no ack; a fetch issued after reset completes normally.
- Back-to-back fetches, busy 1 cycle → fetchAck every 5 cycles; memRequest never high for 2 consecutive cycles.
